mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Parametrised successor to the fixed two-client memory translator. It arbitrates `NUM_RD_PORTS` cache-line read clients (icache, dcache, future PTW/DMA) and one word-write client onto a single main-memory read/write channel pair. Reads are served with round-robin fairness, and read/write ordering is selectable. It sits between the core's cache controllers and `data_mem_top`. Only one memory transaction is outstanding at a time.

## Interface
- `NUM_RD_PORTS`, 2: number of read clients, 1..8.
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 64: write data width; strobe width is `DATA_WIDTH/8`.
- `LINE_WIDTH`, 256: cache line width.
- `WR_FIRST`, 1: 1 = a pending write always beats reads; 0 = write and read alternate when both are pending.

Ports:
- `i_clk` in 1: single clock; everything is rising-edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_rd_req` in `NUM_RD_PORTS`: level request per client, held until that client's done.
- `i_rd_addr` in `NUM_RD_PORTS*ADDR_WIDTH`: packed addresses; client n uses slice [n*ADDR_WIDTH +: ADDR_WIDTH].
- `o_rd_done` out `NUM_RD_PORTS`: one-hot, one-cycle completion pulse.
- `o_rd_line` out `LINE_WIDTH`: registered line, broadcast to all clients; valid while `o_rd_done` is high.
- `i_wr_valid` in 1: write request, held until `o_wr_done`.
- `i_wr_addr` in `ADDR_WIDTH`, `i_wr_data` in `DATA_WIDTH`, `i_wr_strb` in `DATA_WIDTH/8`: write payload.
- `o_wr_done` out 1: one-cycle write completion pulse.
- `o_mem_read_req` out 1, `o_mem_read_address` out `ADDR_WIDTH`: memory read request and address.
- `i_mem_read_done` in 1, `i_cache_line` in `LINE_WIDTH`: memory read completion and returned line.
- `o_mem_write_valid` out 1, `o_mem_write_address` out `ADDR_WIDTH`, `o_mem_write_data` out `DATA_WIDTH`, `o_write_strobe` out `DATA_WIDTH/8`: memory write request and payload.
- `i_mem_write_done` in 1: memory write completion.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE: sample requests and pick a winner.
  - No requests: stay in IDLE.
  - Write wins: latch address, data and strobe into the `o_mem_write_*` registers and go to WR.
  - Read client g wins: latch its address into `o_mem_read_address`, record g, go to RD.
- Read selection: round-robin. Search starts at `last_rd+1` (mod `NUM_RD_PORTS`); `last_rd` updates only on a read grant.
- Read vs write:
  - `WR_FIRST=1`: a pending write wins outright.
  - `WR_FIRST=0`: a toggle bit decides when both are pending. It flips on every grant made while both were pending; after reset it favours the write.
- RD: hold `o_mem_read_req=1` and the address stable until `i_mem_read_done`. Then capture `i_cache_line` into `o_rd_line`, set `o_rd_done[g]=1`, go to RESP.
- WR: hold `o_mem_write_valid=1` and the payload stable until `i_mem_write_done`. Then set `o_wr_done=1`, go to RESP.
- RESP: lasts exactly one cycle, with the done pulse high and the memory request low. Always returns to IDLE.
- Client rule: a client drops its req/valid no later than the cycle after its done. Because IDLE follows RESP, a finished client is never re-granted on the stale request.
- `i_mem_read_done` outside RD and `i_mem_write_done` outside WR are ignored.
- Requests that rise or fall while in RD/WR/RESP have no effect until the next IDLE.
- `o_rd_line` holds its value until the next read completes.

## Timing
- Reset:
  - State = IDLE; `last_rd = NUM_RD_PORTS-1`, so port 0 is served first; toggle favours the write.
  - All outputs are 0, including `o_rd_line` and every `o_mem_*` bus.
- Reset mid-transaction: abort immediately with no done pulse. The memory request drops in the cycle after `i_rst` is sampled.
- Latency:
  - Request visible in IDLE at cycle t → memory request high at t+1.
  - Memory done at cycle k → client done at k+1; memory request low at k+1.
  - Best-case round trip is k=t+1, done at t+2.
- Throughput: at most one transaction per (memory latency + 2) cycles.
- Grant-to-memory output path is registered: no combinational path from `i_*` to `o_mem_*`.

## Test plan
- Single read, port 1, address 0x80, memory returns 0xA5 replicated, done after 3 cycles → `o_mem_read_address=0x80` at t+1; `o_rd_done=2'b10` with `o_rd_line=0xA5..` for exactly one cycle; `o_rd_done[0]` stays 0.
- Ports 0 and 1 request continuously from reset, each re-asserting 1 cycle after its done → grant order 0,1,0,1; no port is served twice in a row.
- `WR_FIRST=1`, write (addr 0x100, data 0x1122334455667788, strb 0xFF) plus a read pending together → write first, read next; `o_write_strobe=0xFF` held through WR.
- `WR_FIRST=0`, write and read pending continuously → order W,R,W,R.
- `i_rst` pulsed while in RD waiting on memory → no `o_rd_done`; all outputs 0 the next cycle; a fresh port-0 request is served normally.
- `NUM_RD_PORTS=3`, spurious `i_mem_read_done` in IDLE, then all ports requesting → spurious pulse ignored; grant order 0,1,2,0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_RD_PORTS cache-line read clients and one word-write client onto a
// single main-memory read/write channel pair, one transaction outstanding at a time.
module mem_req_arbiter #(
    parameter int NUM_RD_PORTS = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int LINE_WIDTH   = 256,
    parameter bit WR_FIRST     = 1'b1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_RD_PORTS-1:0]            i_rd_req,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD_PORTS-1:0]            o_rd_done,
    output logic [LINE_WIDTH-1:0]              o_rd_line,
    input  logic                               i_wr_valid,
    input  logic [ADDR_WIDTH-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH-1:0]              i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]            i_wr_strb,
    output logic                               o_wr_done,
    output logic                               o_mem_read_req,
    output logic [ADDR_WIDTH-1:0]              o_mem_read_address,
    input  logic                               i_mem_read_done,
    input  logic [LINE_WIDTH-1:0]              i_cache_line,
    output logic                               o_mem_write_valid,
    output logic [ADDR_WIDTH-1:0]              o_mem_write_address,
    output logic [DATA_WIDTH-1:0]              o_mem_write_data,
    output logic [DATA_WIDTH/8-1:0]            o_write_strobe,
    input  logic                               i_mem_write_done,
    output logic                               o_busy
);
    localparam int IDX_W  = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_last_rd;
    logic [IDX_W-1:0]          r_rd_sel;
    logic                      r_wr_turn;
    logic [NUM_RD_PORTS-1:0]   r_rd_done;
    logic [LINE_WIDTH-1:0]     r_rd_line;
    logic                      r_wr_done;
    logic                      r_mem_read_req;
    logic [ADDR_WIDTH-1:0]     r_mem_read_address;
    logic                      r_mem_write_valid;
    logic [ADDR_WIDTH-1:0]     r_mem_write_address;
    logic [DATA_WIDTH-1:0]     r_mem_write_data;
    logic [STRB_W-1:0]         r_write_strobe;

    logic                      w_rd_any;
    logic                      w_hi_found;
    logic [IDX_W-1:0]          w_hi_idx;
    logic [IDX_W-1:0]          w_lo_idx;
    logic [IDX_W-1:0]          w_rd_idx;
    logic [ADDR_WIDTH-1:0]     w_rd_addr;
    logic                      w_wr_win;

    // Round-robin: lowest requester above last_rd, otherwise wrap to the lowest requester.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_rd_any   = |i_rd_req;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_rd_addr  = '0;
        for (int i = NUM_RD_PORTS - 1; i >= 0; i--) begin
            if (i_rd_req[i]) begin
                w_lo_idx = IDX_W'(i);
                if (i > int'(r_last_rd)) begin
                    w_hi_idx   = IDX_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_rd_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (w_rd_idx == IDX_W'(i)) begin
                w_rd_addr = i_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        w_wr_win = i_wr_valid && (WR_FIRST || !w_rd_any || r_wr_turn);
    end

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state             <= ST_IDLE;
            r_last_rd           <= IDX_W'(NUM_RD_PORTS - 1);
            r_rd_sel            <= '0;
            r_wr_turn           <= 1'b1;
            r_rd_done           <= '0;
            r_rd_line           <= '0;
            r_wr_done           <= 1'b0;
            r_mem_read_req      <= 1'b0;
            r_mem_read_address  <= '0;
            r_mem_write_valid   <= 1'b0;
            r_mem_write_address <= '0;
            r_mem_write_data    <= '0;
            r_write_strobe      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Fairness toggle only moves when read and write actually contended.
                    if (i_wr_valid && w_rd_any) begin
                        r_wr_turn <= ~r_wr_turn;
                    end
                    if (w_wr_win) begin
                        r_mem_write_address <= i_wr_addr;
                        r_mem_write_data    <= i_wr_data;
                        r_write_strobe      <= i_wr_strb;
                        r_mem_write_valid   <= 1'b1;
                        r_state             <= ST_WR;
                    end else if (w_rd_any) begin
                        r_mem_read_address <= w_rd_addr;
                        r_rd_sel           <= w_rd_idx;
                        r_last_rd          <= w_rd_idx;
                        r_mem_read_req     <= 1'b1;
                        r_state            <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (i_mem_read_done) begin
                        r_mem_read_req <= 1'b0;
                        r_rd_line      <= i_cache_line;
                        r_rd_done      <= NUM_RD_PORTS'(1) << r_rd_sel;
                        r_state        <= ST_RESP;
                    end
                end
                ST_WR: begin
                    if (i_mem_write_done) begin
                        r_mem_write_valid <= 1'b0;
                        r_wr_done         <= 1'b1;
                        r_state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_rd_done <= '0;
                    r_wr_done <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_done           = r_rd_done;
    assign o_rd_line           = r_rd_line;
    assign o_wr_done           = r_wr_done;
    assign o_mem_read_req      = r_mem_read_req;
    assign o_mem_read_address  = r_mem_read_address;
    assign o_mem_write_valid   = r_mem_write_valid;
    assign o_mem_write_address = r_mem_write_address;
    assign o_mem_write_data    = r_mem_write_data;
    assign o_write_strobe      = r_write_strobe;
    assign o_busy              = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-port write-first instance (A) and a
// 3-port alternating instance (B), driven by simple client and memory models.
module tb_mem_req_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 256;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 2 read ports, write-first
    logic [1:0]      a_rd_req;
    logic [2*AW-1:0] a_rd_addr;
    logic [1:0]      a_rd_done;
    logic [LW-1:0]   a_rd_line;
    logic            a_wr_valid;
    logic [AW-1:0]   a_wr_addr;
    logic [DW-1:0]   a_wr_data;
    logic [SW-1:0]   a_wr_strb;
    logic            a_wr_done;
    logic            a_mrd_req;
    logic [AW-1:0]   a_mrd_addr;
    logic            a_mrd_done;
    logic [LW-1:0]   a_line_in;
    logic            a_mwr_valid;
    logic [AW-1:0]   a_mwr_addr;
    logic [DW-1:0]   a_mwr_data;
    logic [SW-1:0]   a_mwr_strb;
    logic            a_mwr_done;
    logic            a_busy;

    // Instance B: 3 read ports, alternating read/write
    logic [2:0]      b_rd_req;
    logic [3*AW-1:0] b_rd_addr;
    logic [2:0]      b_rd_done;
    logic [LW-1:0]   b_rd_line;
    logic            b_wr_valid;
    logic [AW-1:0]   b_wr_addr;
    logic [DW-1:0]   b_wr_data;
    logic [SW-1:0]   b_wr_strb;
    logic            b_wr_done;
    logic            b_mrd_req;
    logic [AW-1:0]   b_mrd_addr;
    logic            b_mrd_done;
    logic [LW-1:0]   b_line_in;
    logic            b_mwr_valid;
    logic [AW-1:0]   b_mwr_addr;
    logic [DW-1:0]   b_mwr_data;
    logic [SW-1:0]   b_mwr_strb;
    logic            b_mwr_done;
    logic            b_busy;

    mem_req_arbiter #(.NUM_RD_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .WR_FIRST(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_rd_req(a_rd_req), .i_rd_addr(a_rd_addr), .o_rd_done(a_rd_done), .o_rd_line(a_rd_line),
        .i_wr_valid(a_wr_valid), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .i_wr_strb(a_wr_strb),
        .o_wr_done(a_wr_done),
        .o_mem_read_req(a_mrd_req), .o_mem_read_address(a_mrd_addr),
        .i_mem_read_done(a_mrd_done), .i_cache_line(a_line_in),
        .o_mem_write_valid(a_mwr_valid), .o_mem_write_address(a_mwr_addr),
        .o_mem_write_data(a_mwr_data), .o_write_strobe(a_mwr_strb),
        .i_mem_write_done(a_mwr_done), .o_busy(a_busy)
    );

    mem_req_arbiter #(.NUM_RD_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .WR_FIRST(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_rd_req(b_rd_req), .i_rd_addr(b_rd_addr), .o_rd_done(b_rd_done), .o_rd_line(b_rd_line),
        .i_wr_valid(b_wr_valid), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_wr_strb(b_wr_strb),
        .o_wr_done(b_wr_done),
        .o_mem_read_req(b_mrd_req), .o_mem_read_address(b_mrd_addr),
        .i_mem_read_done(b_mrd_done), .i_cache_line(b_line_in),
        .o_mem_write_valid(b_mwr_valid), .o_mem_write_address(b_mwr_addr),
        .o_mem_write_data(b_mwr_data), .o_write_strobe(b_mwr_strb),
        .i_mem_write_done(b_mwr_done), .o_busy(b_busy)
    );

    // Model controls: outstanding transactions per client, memory latency, auto-response enable
    int a_rd_left[2] = '{0, 0};
    int a_wr_left    = 0;
    int a_lat        = 1;
    bit a_auto       = 1'b1;
    int a_log[$];
    int b_rd_left[3] = '{0, 0, 0};
    int b_wr_left    = 0;
    int b_lat        = 1;
    bit b_auto       = 1'b1;
    int b_log[$];
    logic [AW-1:0] b_addr_log[$];

    // Clients: hold request until done, drop it in the done cycle, re-assert next cycle if more work.
    // Completion order is logged (port number, 9 = write).
    initial begin
        a_rd_req = '0;
        a_wr_valid = 1'b0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (a_rd_done[n]) begin
                    a_rd_left[n]--;
                    a_rd_req[n] = 1'b0;
                    a_log.push_back(n);
                end else begin
                    a_rd_req[n] = (a_rd_left[n] > 0);
                end
            end
            if (a_wr_done) begin
                a_wr_left--;
                a_wr_valid = 1'b0;
                a_log.push_back(9);
            end else begin
                a_wr_valid = (a_wr_left > 0);
            end
        end
    end

    initial begin
        b_rd_req = '0;
        b_wr_valid = 1'b0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 3; n++) begin
                if (b_rd_done[n]) begin
                    b_rd_left[n]--;
                    b_rd_req[n] = 1'b0;
                    b_log.push_back(n);
                    b_addr_log.push_back(b_mrd_addr);
                end else begin
                    b_rd_req[n] = (b_rd_left[n] > 0);
                end
            end
            if (b_wr_done) begin
                b_wr_left--;
                b_wr_valid = 1'b0;
                b_log.push_back(9);
            end else begin
                b_wr_valid = (b_wr_left > 0);
            end
        end
    end

    // Memory models: pulse done after 'lat' cycles of request
    initial begin
        int rc;
        int wc;
        rc = 0;
        wc = 0;
        a_mrd_done = 1'b0;
        a_mwr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (a_auto) begin
                if (a_mrd_done) a_mrd_done = 1'b0;
                else if (a_mrd_req) begin
                    rc++;
                    if (rc >= a_lat) begin a_mrd_done = 1'b1; rc = 0; end
                end else rc = 0;
                if (a_mwr_done) a_mwr_done = 1'b0;
                else if (a_mwr_valid) begin
                    wc++;
                    if (wc >= a_lat) begin a_mwr_done = 1'b1; wc = 0; end
                end else wc = 0;
            end
        end
    end

    initial begin
        int rc;
        int wc;
        rc = 0;
        wc = 0;
        b_mrd_done = 1'b0;
        b_mwr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (b_auto) begin
                if (b_mrd_done) b_mrd_done = 1'b0;
                else if (b_mrd_req) begin
                    rc++;
                    if (rc >= b_lat) begin b_mrd_done = 1'b1; rc = 0; end
                end else rc = 0;
                if (b_mwr_done) b_mwr_done = 1'b0;
                else if (b_mwr_valid) begin
                    wc++;
                    if (wc >= b_lat) begin b_mwr_done = 1'b1; wc = 0; end
                end else wc = 0;
            end
        end
    end

    task automatic do_reset();
        a_rd_left = '{0, 0};
        a_wr_left = 0;
        b_rd_left = '{0, 0, 0};
        b_wr_left = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_log.delete();
        b_log.delete();
        b_addr_log.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({a_busy, a_rd_done, a_wr_done, a_mrd_req, a_mwr_valid} !== 6'b0) begin
            bad++; $display("FAIL reset_a_ctrl got=%b exp=0", {a_busy, a_rd_done, a_wr_done, a_mrd_req, a_mwr_valid});
        end
        total++; if (a_rd_line !== '0) begin bad++; $display("FAIL reset_a_line got=%h exp=0", a_rd_line); end
        total++; if (a_mrd_addr !== '0) begin bad++; $display("FAIL reset_a_rdaddr got=%h exp=0", a_mrd_addr); end
        total++; if ({a_mwr_addr, a_mwr_data, a_mwr_strb} !== '0) begin
            bad++; $display("FAIL reset_a_wrbus got=%h/%h/%h exp=0", a_mwr_addr, a_mwr_data, a_mwr_strb);
        end
        total++; if ({b_busy, b_rd_done, b_wr_done, b_mrd_req, b_mwr_valid} !== 7'b0) begin
            bad++; $display("FAIL reset_b_ctrl got=%b exp=0", {b_busy, b_rd_done, b_wr_done, b_mrd_req, b_mwr_valid});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        logic [LW-1:0] line_a5;
        line_a5 = {32{8'hA5}};
        a_lat = 3;
        a_rd_addr = {64'h80, 64'h40};
        a_line_in = line_a5;
        @(posedge clk);
        a_rd_left[1] = 1;
        @(negedge clk);
        total++; if ({a_busy, a_mrd_req} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {a_busy, a_mrd_req}); end
        @(negedge clk);
        total++; if ({a_busy, a_mrd_req} !== 2'b11) begin bad++; $display("FAIL single_req got=%b exp=11", {a_busy, a_mrd_req}); end
        total++; if (a_mrd_addr !== 64'h80) begin bad++; $display("FAIL single_addr got=%h exp=80", a_mrd_addr); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if ({a_rd_done, a_mrd_req} !== 3'b001) begin
                bad++; $display("FAIL single_wait%0d got=%b exp=001", i, {a_rd_done, a_mrd_req});
            end
        end
        @(negedge clk);
        total++; if ({a_rd_done, a_mrd_req, a_busy} !== 4'b1001) begin
            bad++; $display("FAIL single_done got=%b exp=1001", {a_rd_done, a_mrd_req, a_busy});
        end
        total++; if (a_rd_line !== line_a5) begin bad++; $display("FAIL single_line got=%h exp=%h", a_rd_line, line_a5); end
        @(negedge clk);
        total++; if ({a_rd_done, a_busy} !== 3'b000) begin bad++; $display("FAIL single_pulse got=%b exp=000", {a_rd_done, a_busy}); end
        total++; if (a_rd_line !== line_a5) begin bad++; $display("FAIL single_hold got=%h exp=%h", a_rd_line, line_a5); end
    endtask

    task automatic test_round_robin();
        int c;
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        do_reset();
        a_lat = 1;
        @(posedge clk);
        a_rd_left = '{2, 2};
        c = 0;
        while (c < 80 && (a_rd_left[0] != 0 || a_rd_left[1] != 0)) begin @(negedge clk); c++; end
        total++; if (c >= 80) begin bad++; $display("FAIL rr_timeout got=%0d/%0d left exp=0/0", a_rd_left[0], a_rd_left[1]); end
        total++;
        if (a_log.size() != 4) begin
            bad++; $display("FAIL rr_count got=%0d exp=4", a_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (a_log[i] != exp_order[i]) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, a_log[i], exp_order[i]); end
            end
        end
    endtask

    task automatic test_wr_first();
        int c;
        do_reset();
        a_lat = 3;
        a_wr_addr = 64'h100;
        a_wr_data = 64'h1122334455667788;
        a_wr_strb = 8'hFF;
        a_rd_addr = {64'h80, 64'h200};
        @(posedge clk);
        a_wr_left = 1;
        a_rd_left[0] = 1;
        c = 0;
        while (c < 10 && !a_mwr_valid) begin @(negedge clk); c++; end
        total++; if (c >= 10) begin bad++; $display("FAIL wf_start_timeout got=%b exp=1", a_mwr_valid); end
        for (int i = 0; i < 3; i++) begin
            total++; if ({a_mwr_valid, a_mrd_req, a_mwr_strb} !== {2'b10, 8'hFF}) begin
                bad++; $display("FAIL wf_hold%0d got=%b exp=10_11111111", i, {a_mwr_valid, a_mrd_req, a_mwr_strb});
            end
            total++; if ({a_mwr_addr, a_mwr_data} !== {64'h100, 64'h1122334455667788}) begin
                bad++; $display("FAIL wf_payload%0d got=%h/%h exp=100/1122334455667788", i, a_mwr_addr, a_mwr_data);
            end
            @(negedge clk);
        end
        total++; if ({a_wr_done, a_mwr_valid} !== 2'b10) begin bad++; $display("FAIL wf_done got=%b exp=10", {a_wr_done, a_mwr_valid}); end
        c = 0;
        while (c < 40 && a_rd_left[0] != 0) begin @(negedge clk); c++; end
        total++; if (c >= 40) begin bad++; $display("FAIL wf_rd_timeout got=%0d left exp=0", a_rd_left[0]); end
        total++; if (a_mrd_addr !== 64'h200) begin bad++; $display("FAIL wf_rdaddr got=%h exp=200", a_mrd_addr); end
        total++;
        if (a_log.size() != 2) begin
            bad++; $display("FAIL wf_count got=%0d exp=2", a_log.size());
        end else begin
            total++; if (a_log[0] != 9 || a_log[1] != 0) begin bad++; $display("FAIL wf_order got=%0d,%0d exp=9,0", a_log[0], a_log[1]); end
        end
    endtask

    task automatic test_mid_reset();
        int c;
        logic [LW-1:0] line_3c;
        line_3c = {32{8'h3C}};
        a_log.delete();
        a_lat = 100;
        a_rd_addr = {64'h80, 64'h240};
        a_line_in = line_3c;
        @(posedge clk);
        a_rd_left[0] = 1;
        c = 0;
        while (c < 10 && !a_mrd_req) begin @(negedge clk); c++; end
        total++; if (c >= 10) begin bad++; $display("FAIL mr_start_timeout got=%b exp=1", a_mrd_req); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++; if ({a_busy, a_rd_done, a_mrd_req, a_wr_done, a_mwr_valid} !== 6'b0) begin
            bad++; $display("FAIL mr_outputs got=%b exp=0", {a_busy, a_rd_done, a_mrd_req, a_wr_done, a_mwr_valid});
        end
        total++; if ({a_mrd_addr, a_rd_line} !== '0) begin bad++; $display("FAIL mr_buses got=%h/%h exp=0", a_mrd_addr, a_rd_line); end
        rst = 1'b0;
        a_lat = 2;
        c = 0;
        while (c < 20 && a_rd_done == 2'b00) begin @(negedge clk); c++; end
        total++; if (a_rd_done !== 2'b01) begin bad++; $display("FAIL mr_fresh_done got=%b exp=01", a_rd_done); end
        total++; if ({a_mrd_addr, a_rd_line} !== {64'h240, line_3c}) begin
            bad++; $display("FAIL mr_fresh_data got=%h/%h exp=240/%h", a_mrd_addr, a_rd_line, line_3c);
        end
        @(negedge clk);
        total++; if (a_log.size() != 1) begin bad++; $display("FAIL mr_done_count got=%0d exp=1", a_log.size()); end
    endtask

    task automatic test_spurious_rr3();
        int c;
        int exp_order[4];
        logic [AW-1:0] exp_addr[4];
        exp_order = '{0, 1, 2, 0};
        exp_addr = '{64'h1000, 64'h1040, 64'h1080, 64'h1000};
        do_reset();
        b_rd_addr = {64'h1080, 64'h1040, 64'h1000};
        @(posedge clk);
        b_auto = 1'b0;
        @(negedge clk);
        b_mrd_done = 1'b1;
        @(negedge clk);
        b_mrd_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++; if ({b_busy, b_rd_done, b_mrd_req} !== 5'b0) begin
                bad++; $display("FAIL sp_ignored%0d got=%b exp=0", i, {b_busy, b_rd_done, b_mrd_req});
            end
            @(negedge clk);
        end
        @(posedge clk);
        b_auto = 1'b1;
        b_lat = 2;
        b_rd_left = '{2, 1, 1};
        c = 0;
        while (c < 100 && (b_rd_left[0] != 0 || b_rd_left[1] != 0 || b_rd_left[2] != 0)) begin @(negedge clk); c++; end
        total++; if (c >= 100) begin bad++; $display("FAIL rr3_timeout got=%0d/%0d/%0d exp=0", b_rd_left[0], b_rd_left[1], b_rd_left[2]); end
        total++;
        if (b_log.size() != 4) begin
            bad++; $display("FAIL rr3_count got=%0d exp=4", b_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (b_log[i] != exp_order[i] || b_addr_log[i] !== exp_addr[i]) begin
                    bad++; $display("FAIL rr3[%0d] got=%0d@%h exp=%0d@%h", i, b_log[i], b_addr_log[i], exp_order[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_wr_alternate();
        int c;
        int exp_order[4];
        exp_order = '{9, 0, 9, 0};
        do_reset();
        b_lat = 1;
        b_wr_addr = 64'h300;
        b_wr_data = 64'hDEADBEEF00C0FFEE;
        b_wr_strb = 8'h0F;
        b_rd_addr = {64'h0, 64'h0, 64'h500};
        @(posedge clk);
        b_wr_left = 2;
        b_rd_left[0] = 2;
        c = 0;
        while (c < 80 && (b_wr_left != 0 || b_rd_left[0] != 0)) begin @(negedge clk); c++; end
        total++; if (c >= 80) begin bad++; $display("FAIL alt_timeout got=%0d/%0d left exp=0/0", b_wr_left, b_rd_left[0]); end
        total++; if ({b_mwr_addr, b_mwr_strb} !== {64'h300, 8'h0F}) begin
            bad++; $display("FAIL alt_wrbus got=%h/%h exp=300/0f", b_mwr_addr, b_mwr_strb);
        end
        total++;
        if (b_log.size() != 4) begin
            bad++; $display("FAIL alt_count got=%0d exp=4", b_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (b_log[i] != exp_order[i]) begin bad++; $display("FAIL alt_order[%0d] got=%0d exp=%0d", i, b_log[i], exp_order[i]); end
            end
        end
    endtask

    initial begin
        a_rd_addr = '0;
        a_wr_addr = '0;
        a_wr_data = '0;
        a_wr_strb = '0;
        a_line_in = '0;
        b_rd_addr = '0;
        b_wr_addr = '0;
        b_wr_data = '0;
        b_wr_strb = '0;
        b_line_in = {32{8'h5A}};
        test_reset();
        test_single_read();
        test_round_robin();
        test_wr_first();
        test_mid_reset();
        test_spurious_rr3();
        test_wr_alternate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
